// File: rtl/alu_out_exec_ctrl.sv
// Execute-stage sequencer: accepts one instruction per handshake, decodes it and
// steers the ALU, shifter, mux_alu_out select and register-file ports until write-back.
//
// state  | meaning
// IDLE   | waiting for an instruction, instr_ready high
// DECODE | read addresses driven; illegal/NOP retire here
// EXEC   | ALU/shifter codes driven, exec down-counter running
// WB     | write-back strobe (suppressed for r0) and done pulse
module alu_out_exec_ctrl #(
  parameter int RAW         = 3,
  parameter int EXEC_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           instr_valid,
  output logic           instr_ready,
  input  logic [15:0]    instr,
  output logic [RAW-1:0] rf_rd_addr_a,
  output logic [RAW-1:0] rf_rd_addr_b,
  output logic [2:0]     alu_op,
  output logic [1:0]     shift_op,
  output logic [2:0]     shamt,
  output logic           output_cont,
  output logic [RAW-1:0] rf_wr_addr,
  output logic           rf_wr_en,
  output logic           busy,
  output logic           done,
  output logic           illegal
);

  // A zero or negative exec length would never leave EXEC; clamp to one cycle.
  localparam int EC = (EXEC_CYCLES < 1) ? 1 : EXEC_CYCLES;
  localparam int CW = (EC > 1) ? $clog2(EC) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  state_t        state;
  logic [15:0]   instr_q;
  logic [CW-1:0] exec_cnt;

  function automatic logic op_is_nop(input logic [3:0] op);
    return op == 4'h0;
  endfunction

  function automatic logic op_is_illegal(input logic [3:0] op);
    return op[3:2] == 2'b11;
  endfunction

  function automatic logic op_is_shift(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

  // Ready is gated by rst_n so nothing is accepted while reset is applied.
  always_comb begin
    instr_ready = rst_n && (state == IDLE);
    busy        = (state != IDLE);
  end

  // Sequencer: state, latched instruction, exec counter and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      instr_q      <= '0;
      exec_cnt     <= '0;
      rf_rd_addr_a <= '0;
      rf_rd_addr_b <= '0;
      alu_op       <= '0;
      shift_op     <= '0;
      shamt        <= '0;
      output_cont  <= 1'b0;
      rf_wr_addr   <= '0;
      rf_wr_en     <= 1'b0;
      done         <= 1'b0;
      illegal      <= 1'b0;
    end else begin
      rf_wr_en <= 1'b0;
      done     <= 1'b0;
      illegal  <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            instr_q      <= instr;
            // Read addresses and the DECODE-cycle strobes come straight from the
            // incoming word so they are visible during DECODE itself.
            rf_rd_addr_a <= RAW'(instr[8:6]);
            rf_rd_addr_b <= RAW'(instr[5:3]);
            illegal      <= op_is_illegal(instr[15:12]);
            done         <= op_is_nop(instr[15:12]);
            state        <= DECODE;
          end
        end
        DECODE: begin
          rf_rd_addr_a <= RAW'(instr_q[8:6]);
          rf_rd_addr_b <= RAW'(instr_q[5:3]);
          if (op_is_illegal(instr_q[15:12]) || op_is_nop(instr_q[15:12])) begin
            state <= IDLE;
          end else begin
            exec_cnt <= CW'(EC - 1);
            if (op_is_shift(instr_q[15:12])) begin
              output_cont <= 1'b1;
              alu_op      <= '0;
              shift_op    <= instr_q[13:12];
              shamt       <= instr_q[2:0];
            end else begin
              output_cont <= 1'b0;
              alu_op      <= instr_q[14:12];
              shift_op    <= '0;
              shamt       <= '0;
            end
            state <= EXEC;
          end
        end
        EXEC: begin
          if (exec_cnt == '0) begin
            rf_wr_addr <= RAW'(instr_q[11:9]);
            rf_wr_en   <= (instr_q[11:9] != 3'd0);
            done       <= 1'b1;
            state      <= WB;
          end else begin
            exec_cnt <= exec_cnt - 1'b1;
          end
        end
        WB: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
